// File: rtl/pi_actuator_pkg.sv
// Shared types and constants for the PI output actuator and its SPI DAC transmitter.
package pi_actuator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } tx_state_t;

  localparam int FRAME_BITS = 24;
  localparam logic [7:0] DEFAULT_CMD_BYTE = 8'h30;

  // Signed two's complement to DAC offset-binary code.
  function automatic logic [15:0] to_offset_binary(input logic [15:0] x);
    return {~x[15], x[14:0]};
  endfunction

endpackage

// File: rtl/spi_dac_tx.sv
// 24-bit SPI write engine: start -> cs_n low next edge, frame plus gap occupies 51*CLK_DIV cycles.
// No backpressure: start is only honoured in IDLE, busy covers the whole frame including the gap.
module spi_dac_tx
  import pi_actuator_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  busy,
  output logic                  dac_cs_n,
  output logic                  dac_sclk,
  output logic                  dac_mosi
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  tx_state_t             state;
  logic [CW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  div_done;

  assign div_done = (div_cnt == DIV_LAST);
  assign dac_mosi = shreg[FRAME_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      dac_cs_n <= 1'b1;
      dac_sclk <= 1'b0;
    end else begin
      div_cnt <= div_done ? '0 : div_cnt + CW'(1);
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (start) begin
            state    <= CS_SETUP;
            busy     <= 1'b1;
            dac_cs_n <= 1'b0;
            shreg    <= word;
          end
        end
        CS_SETUP: begin
          if (div_done) begin
            state    <= SHIFT;
            dac_sclk <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          // Each bit is a high half then a low half; data advances on the falling edge.
          if (div_done) begin
            if (dac_sclk) begin
              dac_sclk <= 1'b0;
              shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
            end else if (bit_cnt == BIT_LAST) begin
              state <= CS_HOLD;
            end else begin
              bit_cnt  <= bit_cnt + BW'(1);
              dac_sclk <= 1'b1;
            end
          end
        end
        CS_HOLD: begin
          if (div_done) begin
            state    <= GAP;
            dac_cs_n <= 1'b1;
          end
        end
        GAP: begin
          if (div_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pi_output_actuator.sv
// Clamps and slew-limits PI samples, then writes them to the DAC; conditioning 1 cycle after capture.
// No backpressure: a one-deep pending slot is overwritten while the transmitter is busy (counted in drop_count).
module pi_output_actuator
  import pi_actuator_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         CLK_DIV  = 4,
  parameter logic [7:0] CMD_BYTE = DEFAULT_CMD_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] pi_output,
  input  logic              pi_output_valid,
  input  logic [DATA_W-1:0] limit_low,
  input  logic [DATA_W-1:0] limit_high,
  input  logic [DATA_W-1:0] slew_max,
  output logic              pi_limiting,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_mosi,
  output logic              busy,
  output logic [15:0]       drop_count
);

  logic signed [DATA_W-1:0] ll, lh;
  logic signed [DATA_W-1:0] pend_dat, last_sent;
  logic                     pend_vld;
  logic                     start_q;
  logic [FRAME_BITS-1:0]    word_q;
  logic                     tx_busy;

  logic signed [DATA_W-1:0] lo_sel, clamped, slewed;
  logic signed [DATA_W:0]   delta, step_up, step_dn, slew_ext;
  logic [DATA_W:0]          delta_mag;
  logic                     clamp_hit, slew_hit;
  logic                     capture, cond_fire;
  logic [DATA_W-1:0]        code;

  assign ll = limit_low;
  assign lh = limit_high;

  assign capture = enable && pi_output_valid;
  // start_q blocks a second conditioning in the cycle before the transmitter reports busy.
  assign cond_fire = enable && pend_vld && !tx_busy && !start_q;

  always_comb begin
    lo_sel    = (pend_dat < ll) ? ll : pend_dat;
    clamped   = (lo_sel > lh) ? lh : lo_sel;
    clamp_hit = (clamped != pend_dat);

    slew_ext  = signed'({1'b0, slew_max});
    delta     = {clamped[DATA_W-1], clamped} - {last_sent[DATA_W-1], last_sent};
    delta_mag = unsigned'(delta[DATA_W] ? -delta : delta);
    slew_hit  = (slew_max != '0) && (delta_mag > {1'b0, slew_max});
    step_up   = {last_sent[DATA_W-1], last_sent} + slew_ext;
    step_dn   = {last_sent[DATA_W-1], last_sent} - slew_ext;

    slewed = clamped;
    if (slew_hit) begin
      slewed = delta[DATA_W] ? step_dn[DATA_W-1:0] : step_up[DATA_W-1:0];
    end
    code = {~slewed[DATA_W-1], slewed[DATA_W-2:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_vld    <= 1'b0;
      pend_dat    <= '0;
      last_sent   <= '0;
      start_q     <= 1'b0;
      word_q      <= '0;
      pi_limiting <= 1'b0;
      drop_count  <= '0;
    end else begin
      start_q <= cond_fire;

      if (cond_fire) begin
        last_sent   <= slewed;
        pi_limiting <= clamp_hit | slew_hit;
        word_q      <= FRAME_BITS'({CMD_BYTE, code});
      end else if (!enable) begin
        pi_limiting <= 1'b0;
      end

      if (!enable) begin
        pend_vld <= 1'b0;
      end else if (capture) begin
        pend_dat <= pi_output;
        pend_vld <= 1'b1;
        if (pend_vld && !cond_fire && (drop_count != 16'hFFFF)) begin
          drop_count <= drop_count + 16'd1;
        end
      end else if (cond_fire) begin
        pend_vld <= 1'b0;
      end
    end
  end

  spi_dac_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (start_q),
    .word     (word_q),
    .busy     (tx_busy),
    .dac_cs_n (dac_cs_n),
    .dac_sclk (dac_sclk),
    .dac_mosi (dac_mosi)
  );

  assign busy = tx_busy;

endmodule

// File: tb/tb_pi_output_actuator.sv
// Scoreboard bench: stimulus queues expected DAC frames, an SPI monitor decodes and checks them.
module tb_pi_output_actuator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pi_output_valid = 1'b0;
  logic [15:0] pi_output = 16'h0000;
  logic [15:0] limit_low = 16'h8001;
  logic [15:0] limit_high = 16'h7FFF;
  logic [15:0] slew_max = 16'h0000;
  logic        pi_limiting, dac_cs_n, dac_sclk, dac_mosi, busy;
  logic [15:0] drop_count;

  int   tests = 0;
  int   fails = 0;
  int   frames_seen = 0;
  logic aborting = 1'b0;

  typedef struct packed {
    logic [23:0] word;
    logic        lim;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  pi_output_actuator dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .pi_output       (pi_output),
    .pi_output_valid (pi_output_valid),
    .limit_low       (limit_low),
    .limit_high      (limit_high),
    .slew_max        (slew_max),
    .pi_limiting     (pi_limiting),
    .dac_cs_n        (dac_cs_n),
    .dac_sclk        (dac_sclk),
    .dac_mosi        (dac_mosi),
    .busy            (busy),
    .drop_count      (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] code, input logic lim);
    sb_q.push_back({8'h30, code, lim});
  endtask

  task automatic send(input logic [15:0] s);
    @(negedge clk);
    pi_output = s;
    pi_output_valid = 1'b1;
    @(negedge clk);
    pi_output_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("busy_rise", busy, 1);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    check("busy_fall", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cs_low();
    int n;
    n = 0;
    while (dac_cs_n && n < 10) begin @(negedge clk); n++; end
    check("cs_low_start", dac_cs_n, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // SPI monitor: decode each frame on sclk rising edges and compare with the scoreboard.
  initial begin
    logic        prev_cs, prev_sclk, lim_start;
    logic [23:0] rx;
    int          nbits, low_cycles;
    exp_t        e;
    prev_cs = 1'b1; prev_sclk = 1'b0; lim_start = 1'b0;
    rx = '0; nbits = 0; low_cycles = 0;
    forever begin
      @(negedge clk);
      if (prev_cs && !dac_cs_n) begin
        rx = '0; nbits = 0; low_cycles = 0;
        lim_start = pi_limiting;
      end
      if (!dac_cs_n) begin
        low_cycles++;
        if (!prev_sclk && dac_sclk) begin
          rx = {rx[22:0], dac_mosi};
          nbits++;
        end
      end
      if (!prev_cs && dac_cs_n) begin
        if (aborting) begin
          aborting = 1'b0;
        end else begin
          check("frame_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("frame_word", rx, e.word);
            check("frame_bits", nbits, 24);
            check("cs_low_cycles", low_cycles, 200);
            check("frame_limiting", lim_start, e.lim);
          end
          frames_seen++;
        end
      end
      prev_cs = dac_cs_n;
      prev_sclk = dac_sclk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs;
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cs_n", dac_cs_n, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_mosi", dac_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_limiting", pi_limiting, 0);
    check("rst_drop", drop_count, 0);
    enable = 1'b1;

    // Basic frame
    expect_frame(16'h9000, 1'b0); send(16'h1000); wait_frame();
    check("basic_limiting", pi_limiting, 0);

    // Clamp cases
    limit_high = 16'h2000;
    expect_frame(16'hA000, 1'b1); send(16'h4000); wait_frame();
    check("clamp_limiting", pi_limiting, 1);
    expect_frame(16'h8100, 1'b0); send(16'h0100); wait_frame();
    check("unclamp_limiting", pi_limiting, 0);
    limit_low = 16'h1000; limit_high = 16'h0800;
    expect_frame(16'h8800, 1'b1); send(16'h0000); wait_frame();
    limit_low = 16'hF000; limit_high = 16'h7FFF;
    expect_frame(16'h7000, 1'b1); send(16'h8000); wait_frame();
    limit_low = 16'h8001;

    // Slew ramp from midscale, both directions
    do_reset();
    slew_max = 16'h0100;
    expect_frame(16'h8100, 1'b1); send(16'h1000); wait_frame();
    expect_frame(16'h8200, 1'b1); send(16'h1000); wait_frame();
    expect_frame(16'h8300, 1'b1); send(16'h1000); wait_frame();
    expect_frame(16'h8200, 1'b1); send(16'hFF00); wait_frame();
    expect_frame(16'h8280, 1'b0); send(16'h0280); wait_frame();
    check("slew_within_limiting", pi_limiting, 0);

    // Overrun: 500 back-to-back samples 0x0100+c; frames at captures 0, 206, 412 and the last (499)
    slew_max = 16'h0000;
    check("drop_before_overrun", drop_count, 0);
    expect_frame(16'h8100, 1'b0);
    expect_frame(16'h81CE, 1'b0);
    expect_frame(16'h829C, 1'b0);
    expect_frame(16'h82F3, 1'b0);
    @(negedge clk);
    pi_output_valid = 1'b1;
    pi_output = 16'h0100;
    for (int c = 1; c < 500; c++) begin
      @(negedge clk);
      pi_output = 16'h0100 + 16'(c);
    end
    @(negedge clk);
    pi_output_valid = 1'b0;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 1500) begin @(negedge clk); n++; end
    check("overrun_drained", sb_q.size(), 0);
    check("overrun_drop", drop_count, 496);
    repeat (3) @(negedge clk);

    // Enable drop mid-frame
    limit_high = 16'h2000;
    expect_frame(16'hA000, 1'b1);
    fs = frames_seen;
    send(16'h4000);
    wait_cs_low();
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (3) send(16'h1234);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    check("en_busy_fall", busy, 0);
    check("en_frame_done", frames_seen, fs + 1);
    check("en_limiting", pi_limiting, 0);
    fs = frames_seen;
    for (int k = 0; k < 30; k++) begin
      send(16'h2222);
      repeat (8) @(negedge clk);
    end
    check("en_no_frames", frames_seen, fs);
    check("en_drop_held", drop_count, 496);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("en_no_stale", busy, 0);
    limit_high = 16'h7FFF;

    // Reset mid-SHIFT
    send(16'h4000);
    wait_cs_low();
    repeat (60) @(negedge clk);
    aborting = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n", dac_cs_n, 1);
    check("mid_rst_sclk", dac_sclk, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", drop_count, 0);
    reset = 1'b0;
    slew_max = 16'h0100;
    expect_frame(16'h8100, 1'b1); send(16'h1000); wait_frame();

    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("queue_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
